// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate decoder feeding an elastic
// valid/ready register pipeline with flush and occupancy tracking.
module imm_extend_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:7]     instr,
    input  logic [2:0]      ImmSrc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ImmExt,
    output logic            illegal,
    output logic [2:0]      occupancy
);

    localparam int LAST = STAGES - 1;

    logic [XLEN-1:0] decImm;
    logic            decIll;

    logic [LAST:0]   stageVld;
    logic [XLEN-1:0] stageData [STAGES];
    logic [LAST:0]   stageIll;

    logic [STAGES:0] canTake;
    logic [LAST:0]   adv;
    logic [LAST:0]   load;
    logic [XLEN-1:0] srcData [STAGES];
    logic [LAST:0]   srcIll;

    logic            accept;
    logic            outXfer;
    logic [2:0]      occCount;

    // Decode the immediate for the selected format, sign bit is instr[31]
    always_comb begin
        decImm = '0;
        decIll = 1'b0;
        unique case (ImmSrc)
            3'b000: decImm = {{(XLEN-12){instr[31]}},
                              instr[31:20]};
            3'b001: decImm = {{(XLEN-12){instr[31]}},
                              instr[31:25], instr[11:7]};
            3'b010: decImm = {{(XLEN-12){instr[31]}},
                              instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            3'b011: decImm = {{(XLEN-20){instr[31]}},
                              instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            3'b100: decImm = {{(XLEN-31){instr[31]}},
                              instr[30:12], 12'b0};
            3'b101: decImm = {{(XLEN-5){1'b0}},
                              instr[19:15]};
            3'b110: decImm = {{(XLEN-6){1'b0}},
                              (XLEN == 64) ? instr[25] : 1'b0,
                              instr[24:20]};
            default: decIll = 1'b1;
        endcase
    end

    // Ready chain from the output back to stage 0, plus stage sources
    always_comb begin
        canTake         = '0;
        adv             = '0;
        load            = '0;
        srcIll          = '0;
        canTake[STAGES] = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            adv[k]     = stageVld[k] & canTake[k+1];
            canTake[k] = ~stageVld[k] | adv[k];
        end
        load[0]    = in_valid & canTake[0];
        srcData[0] = decImm;
        srcIll[0]  = decIll;
        for (int k = 1; k < STAGES; k++) begin
            load[k]    = adv[k-1];
            srcData[k] = stageData[k-1];
            srcIll[k]  = stageIll[k-1];
        end
    end

    assign in_ready  = canTake[0];
    assign accept    = in_valid & canTake[0];
    assign outXfer   = stageVld[LAST] & out_ready;

    assign out_valid = stageVld[LAST];
    assign ImmExt    = stageData[LAST];
    assign illegal   = stageIll[LAST];
    assign occupancy = occCount;

    // Stage registers; the last stage zeroes its payload when it empties
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stageVld <= '0;
            stageIll <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stageData[k] <= '0;
            end
        end else if (flush) begin
            stageVld        <= '0;
            stageData[LAST] <= '0;
            stageIll[LAST]  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    stageVld[k]  <= 1'b1;
                    stageData[k] <= srcData[k];
                    stageIll[k]  <= srcIll[k];
                end else if (adv[k]) begin
                    stageVld[k] <= 1'b0;
                    if (k == LAST) begin
                        stageData[k] <= '0;
                        stageIll[k]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Occupancy tracks accepts minus output transfers, cleared on flush
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occCount <= 3'd0;
        end else if (flush) begin
            occCount <= 3'd0;
        end else begin
            unique case ({accept, outXfer})
                2'b10:   occCount <= occCount + 3'd1;
                2'b01:   occCount <= occCount - 3'd1;
                default: occCount <= occCount;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed checks of decode, handshake, flush
// and reset on a 32-bit and a 64-bit instance sharing one stimulus.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] word = 32'h0;
    logic [2:0]  immSrc = 3'b000;
    logic [31:7] instr;

    logic        inReady32, outValid32, ill32;
    logic [31:0] imm32;
    logic [2:0]  occ32;
    logic        inReady64, outValid64, ill64;
    logic [63:0] imm64;
    logic [2:0]  occ64;

    int total = 0;
    int bad = 0;

    assign instr = word[31:7];

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .STAGES(2)) dut32 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(inReady32),
        .instr(instr), .ImmSrc(immSrc), .flush(flush),
        .out_valid(outValid32), .out_ready(out_ready),
        .ImmExt(imm32), .illegal(ill32), .occupancy(occ32)
    );

    imm_extend_pipe #(.XLEN(64), .STAGES(2)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(inReady64),
        .instr(instr), .ImmSrc(immSrc), .flush(flush),
        .out_valid(outValid64), .out_ready(out_ready),
        .ImmExt(imm64), .illegal(ill64), .occupancy(occ64)
    );

    logic [2:0]  srcTab [14] = '{
        3'b000, 3'b000, 3'b001, 3'b010, 3'b010, 3'b011, 3'b011,
        3'b011, 3'b100, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111};
    logic [31:0] wordTab [14] = '{
        32'hFFF00000, 32'h7FF00000, 32'h80000080, 32'h80000000,
        32'h00000080, 32'h00100000, 32'h000FF000, 32'h80000000,
        32'h80000000, 32'h12345000, 32'h000F8000, 32'h800F8000,
        32'h03F00000, 32'hFFFFFF80};
    logic [31:0] e32Tab [14] = '{
        32'hFFFFFFFF, 32'h000007FF, 32'hFFFFF801, 32'hFFFFF000,
        32'h00000800, 32'h00000800, 32'h000FF000, 32'hFFF00000,
        32'h80000000, 32'h12345000, 32'h0000001F, 32'h0000001F,
        32'h0000001F, 32'h00000000};
    logic [63:0] e64Tab [14] = '{
        64'hFFFFFFFFFFFFFFFF, 64'h00000000000007FF,
        64'hFFFFFFFFFFFFF801, 64'hFFFFFFFFFFFFF000,
        64'h0000000000000800, 64'h0000000000000800,
        64'h00000000000FF000, 64'hFFFFFFFFFFF00000,
        64'hFFFFFFFF80000000, 64'h0000000012345000,
        64'h000000000000001F, 64'h000000000000001F,
        64'h000000000000003F, 64'h0000000000000000};
    logic        illTab [14] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        total++;
        if (outValid32 !== 1'b0 || outValid64 !== 1'b0) begin
            bad++;
            $display("FAIL reset out_valid: got %b/%b want 0",
                     outValid32, outValid64);
        end
        total++;
        if (occ32 !== 3'd0 || occ64 !== 3'd0) begin
            bad++;
            $display("FAIL reset occupancy: got %0d/%0d want 0",
                     occ32, occ64);
        end
        total++;
        if (imm32 !== 32'h0 || imm64 !== 64'h0 ||
            ill32 !== 1'b0 || ill64 !== 1'b0) begin
            bad++;
            $display("FAIL reset data: got %h/%h ill %b/%b want 0",
                     imm32, imm64, ill32, ill64);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (inReady32 !== 1'b1 || inReady64 !== 1'b1) begin
            bad++;
            $display("FAIL reset in_ready: got %b/%b want 1",
                     inReady32, inReady64);
        end
        step();
    endtask

    task automatic test_decode();
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            immSrc   = srcTab[i];
            word     = wordTab[i];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            total++;
            if (outValid32 !== 1'b0) begin
                bad++;
                $display("FAIL decode[%0d] early valid: got %b want 0",
                         i, outValid32);
            end
            step();
            total++;
            if (outValid32 !== 1'b1 || outValid64 !== 1'b1) begin
                bad++;
                $display("FAIL decode[%0d] valid: got %b/%b want 1",
                         i, outValid32, outValid64);
            end
            total++;
            if (imm32 !== e32Tab[i]) begin
                bad++;
                $display("FAIL decode[%0d] imm32: got %h want %h",
                         i, imm32, e32Tab[i]);
            end
            total++;
            if (imm64 !== e64Tab[i]) begin
                bad++;
                $display("FAIL decode[%0d] imm64: got %h want %h",
                         i, imm64, e64Tab[i]);
            end
            total++;
            if (ill32 !== illTab[i] || ill64 !== illTab[i]) begin
                bad++;
                $display("FAIL decode[%0d] illegal: got %b/%b want %b",
                         i, ill32, ill64, illTab[i]);
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        immSrc    = 3'b000;
        word      = 32'h00100000;
        in_valid  = 1'b1;
        step();
        total++;
        if (inReady32 !== 1'b1) begin
            bad++;
            $display("FAIL bp second ready: got %b want 1", inReady32);
        end
        word = 32'h00200000;
        step();
        word = 32'h00300000;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (inReady32 !== 1'b0 || inReady64 !== 1'b0) begin
                bad++;
                $display("FAIL bp stall ready c%0d: got %b want 0",
                         c, inReady32);
            end
            total++;
            if (outValid32 !== 1'b1 || imm32 !== 32'h1 ||
                imm64 !== 64'h1) begin
                bad++;
                $display("FAIL bp hold c%0d: got v%b %h want v1 1",
                         c, outValid32, imm32);
            end
            total++;
            if (occ32 !== 3'd2 || occ64 !== 3'd2) begin
                bad++;
                $display("FAIL bp occ c%0d: got %0d want 2", c, occ32);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (inReady32 !== 1'b1) begin
            bad++;
            $display("FAIL bp release ready: got %b want 1", inReady32);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (outValid32 !== 1'b1 || imm32 !== 32'h2 || occ32 !== 3'd2) begin
            bad++;
            $display("FAIL bp drain1: got v%b %h occ%0d want v1 2 occ2",
                     outValid32, imm32, occ32);
        end
        step();
        total++;
        if (outValid32 !== 1'b1 || imm32 !== 32'h3 || occ32 !== 3'd1) begin
            bad++;
            $display("FAIL bp drain2: got v%b %h occ%0d want v1 3 occ1",
                     outValid32, imm32, occ32);
        end
        step();
        total++;
        if (outValid32 !== 1'b0 || imm32 !== 32'h0 || occ32 !== 3'd0) begin
            bad++;
            $display("FAIL bp empty: got v%b %h occ%0d want v0 0 occ0",
                     outValid32, imm32, occ32);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expImm;
        out_ready = 1'b1;
        immSrc    = 3'b000;
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                in_valid = 1'b1;
                word     = (32'h10 + 32'(c)) << 20;
            end else begin
                in_valid = 1'b0;
            end
            total++;
            if (inReady32 !== 1'b1) begin
                bad++;
                $display("FAIL b2b ready c%0d: got %b want 1",
                         c, inReady32);
            end
            step();
            if (c >= 1 && c <= 5) begin
                expImm = 32'h10 + 32'(c - 1);
                total++;
                if (outValid32 !== 1'b1 || imm32 !== expImm) begin
                    bad++;
                    $display("FAIL b2b out c%0d: got v%b %h want v1 %h",
                             c, outValid32, imm32, expImm);
                end
            end else begin
                total++;
                if (outValid32 !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b idle c%0d: got v%b want v0",
                             c, outValid32);
                end
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        immSrc    = 3'b000;
        in_valid  = 1'b1;
        word      = 32'h02100000;
        step();
        word = 32'h02200000;
        step();
        total++;
        if (outValid32 !== 1'b1 || imm32 !== 32'h21 || occ32 !== 3'd2) begin
            bad++;
            $display("FAIL flush pre: got v%b %h occ%0d want v1 21 occ2",
                     outValid32, imm32, occ32);
        end
        word  = 32'h02300000;
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (outValid32 !== 1'b0 || outValid64 !== 1'b0 ||
            imm32 !== 32'h0) begin
            bad++;
            $display("FAIL flush valid: got v%b/%b %h want v0 0",
                     outValid32, outValid64, imm32);
        end
        total++;
        if (occ32 !== 3'd0 || occ64 !== 3'd0) begin
            bad++;
            $display("FAIL flush occ: got %0d/%0d want 0", occ32, occ64);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (outValid32 !== 1'b0) begin
                bad++;
                $display("FAIL flush late valid c%0d: got %b want 0",
                         c, outValid32);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        immSrc    = 3'b000;
        in_valid  = 1'b1;
        word      = 32'h04400000;
        step();
        step();
        in_valid = 1'b0;
        total++;
        if (occ32 !== 3'd2 || outValid32 !== 1'b1) begin
            bad++;
            $display("FAIL rmid pre: got occ%0d v%b want occ2 v1",
                     occ32, outValid32);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (outValid32 !== 1'b0 || outValid64 !== 1'b0) begin
            bad++;
            $display("FAIL rmid out_valid: got %b/%b want 0",
                     outValid32, outValid64);
        end
        total++;
        if (occ32 !== 3'd0 || occ64 !== 3'd0 || imm32 !== 32'h0) begin
            bad++;
            $display("FAIL rmid state: got occ%0d/%0d %h want 0",
                     occ32, occ64, imm32);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (inReady32 !== 1'b1 || inReady64 !== 1'b1) begin
            bad++;
            $display("FAIL rmid in_ready: got %b/%b want 1",
                     inReady32, inReady64);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        word      = 32'h05500000;
        step();
        in_valid = 1'b0;
        total++;
        if (occ32 !== 3'd1 || outValid32 !== 1'b0) begin
            bad++;
            $display("FAIL rmid accept: got occ%0d v%b want occ1 v0",
                     occ32, outValid32);
        end
        step();
        total++;
        if (outValid32 !== 1'b1 || imm32 !== 32'h55) begin
            bad++;
            $display("FAIL rmid out: got v%b %h want v1 55",
                     outValid32, imm32);
        end
        step();
        total++;
        if (outValid32 !== 1'b0 || occ32 !== 3'd0) begin
            bad++;
            $display("FAIL rmid tail: got v%b occ%0d want v0 occ0",
                     outValid32, occ32);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
